// File: rtl/candy_wb.sv
`default_nettype none
// ============================================================================
//  Module   : candy_wb
//  Purpose  : Register-file write-back unit for the candy CPU. Merges the
//             never-stalling ALU result path and the valid/ready load-return
//             path into the single write port of candy_regs. Loads that lose
//             arbitration wait in an in-order FIFO; buffered loads made stale
//             by a younger ALU write to the same register are squashed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    reset        in   asynchronous, active-high reset
//    alu_valid    in   ALU result present this cycle
//    alu_rd       in   ALU destination register
//    alu_data     in   ALU result
//    ld_valid     in   load return offered
//    ld_ready     out  load accepted when ld_valid & ld_ready
//    ld_rd        in   load destination register
//    ld_data      in   load data
//    write_enable out  regfile write strobe (registered)
//    waddr        out  regfile write address (registered)
//    wdata        out  regfile write data (registered)
//    pending      out  bit r set iff a live buffered load targets r (registered)
//    ld_count     out  load FIFO occupancy (registered)
// ============================================================================
module candy_wb #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_rd,
  input  logic [DATA_W-1:0]         ld_data,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [(1<<ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    ld_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_NREG  = 1 << ADDR_W;

  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  // FIFO storage: payload is not reset, only pointers/live bits are.
  logic [ADDR_W-1:0]  ent_rd_q   [DEPTH];
  logic [DATA_W-1:0]  ent_data_q [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [c_PTR_W-1:0] head_q, head_d;
  logic [c_PTR_W-1:0] tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  // Registered outputs
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [c_NREG-1:0]  pending_q, pending_d;

  logic               w_accept;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_slot_rd [DEPTH];

  // Ready depends only on registered occupancy (and reset), never on ld_valid.
  assign ld_ready = !reset && (count_q != c_FULL);
  assign w_accept = ld_valid && ld_ready;
  assign w_empty  = (count_q == '0);

  // --------------------------------------------------------------------------
  // Arbitration, squash and FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    w_push  = 1'b0;
    w_pop   = 1'b0;

    if (alu_valid) begin
      we_d    = 1'b1;
      waddr_d = alu_rd;
      wdata_d = alu_data;
      w_push  = w_accept;
      // Every buffered load is older than this ALU write, so a matching
      // destination makes it stale. Unoccupied slots already have live=0.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == alu_rd) begin
          live_d[i] = 1'b0;
        end
      end
    end else if (!w_empty) begin
      w_pop  = 1'b1;
      w_push = w_accept;
      // A squashed head burns the cycle; address/data hold like an idle cycle.
      if (live_q[head_q]) begin
        we_d    = 1'b1;
        waddr_d = ent_rd_q[head_q];
        wdata_d = ent_data_q[head_q];
      end
      live_d[head_q] = 1'b0;
    end else if (w_accept) begin
      // Empty FIFO and idle ALU: load bypasses the buffer entirely.
      we_d    = 1'b1;
      waddr_d = ld_rd;
      wdata_d = ld_data;
    end

    if (w_push) begin
      // A load pushed alongside a same-rd ALU write is born squashed.
      live_d[tail_q] = !(alu_valid && (ld_rd == alu_rd));
      tail_d         = tail_q + c_PTR_ONE;
    end
    if (w_pop) begin
      head_d = head_q + c_PTR_ONE;
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Destination of each slot after this edge (the pushed slot takes ld_rd).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_rd[i] = ent_rd_q[i];
      if (w_push && (tail_q == c_PTR_W'(i))) begin
        w_slot_rd[i] = ld_rd;
      end
    end
  end

  // Pending mask reflects the post-edge FIFO contents.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) begin
        pending_d[w_slot_rd[i]] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      live_q    <= live_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      ent_rd_q[tail_q]   <= ld_rd;
      ent_data_q[tail_q] <= ld_data;
    end
  end

  assign write_enable = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign pending      = pending_q;
  assign ld_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_candy_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_candy_wb
//  Purpose  : Self-checking bench for candy_wb. A queue-based reference model
//             predicts every cycle's outcome; a monitor compares DUT outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_candy_wb;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              write_enable;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  ld_count;

  candy_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .write_enable (write_enable),
    .waddr        (waddr),
    .wdata        (wdata),
    .pending      (pending),
    .ld_count     (ld_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    bit                live;
  } ent_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                count;
    logic [NREG-1:0]   pend;
    bit                ready;
  } st_t;

  ent_t mq[$];   // model FIFO, oldest first
  wr_t  wq[$];   // expected register writes, in order
  st_t  sq[$];   // expected per-cycle status

  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  int  checks = 0;
  int  errors = 0;
  bit  in_reset = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called at a falling edge), advance the model,
  // queue the expectations, and return at the next falling edge.
  task automatic cycle(input bit av, input logic [ADDR_W-1:0] ard,
                       input logic [DATA_W-1:0] ad, input bit lv,
                       input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldd,
                       output bit acc);
    st_t  s;
    ent_t e;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldd;

    acc  = lv && (mq.size() != DEPTH);
    s.we = 1'b0;
    if (av) begin
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].rd == ard) mq[i].live = 1'b0;
      s.we = 1'b1; m_addr = ard; m_data = ad;
      if (acc) mq.push_back('{lrd, ldd, (lrd != ard)});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin s.we = 1'b1; m_addr = e.rd; m_data = e.data; end
      if (acc) mq.push_back('{lrd, ldd, 1'b1});
    end else if (acc) begin
      s.we = 1'b1; m_addr = lrd; m_data = ldd;
    end
    if (s.we) wq.push_back('{m_addr, m_data});
    s.addr  = m_addr;
    s.data  = m_data;
    s.count = mq.size();
    s.pend  = '0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].live) s.pend[mq[i].rd] = 1'b1;
    s.ready = (mq.size() != DEPTH);
    sq.push_back(s);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_write_enable"}, write_enable, 0);
    chk({tag, "_waddr"},        waddr, 0);
    chk({tag, "_wdata"},        wdata, 0);
    chk({tag, "_pending"},      pending, 0);
    chk({tag, "_ld_count"},     ld_count, 0);
    chk({tag, "_ld_ready"},     ld_ready, 0);
  endtask

  // Asynchronous reset between edges; called at a falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    in_reset = 1'b1;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    check_reset_vals("async_reset");
    mq.delete(); wq.delete(); sq.delete();
    m_addr = '0; m_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_reset = 1'b0;
  endtask

  // Monitor: compares outputs shortly after every rising edge.
  st_t mon_s;
  wr_t mon_w;
  always begin
    @(posedge clk);
    #1;
    if (!in_reset) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue: got empty expected entry at %0t", $time);
      end else begin
        mon_s = sq.pop_front();
        chk("write_enable", write_enable, mon_s.we);
        chk("waddr_hold",   waddr, mon_s.addr);
        chk("wdata_hold",   wdata, mon_s.data);
        chk("ld_count",     ld_count, mon_s.count);
        chk("pending",      pending, mon_s.pend);
        chk("ld_ready",     ld_ready, mon_s.ready);
      end
      if (write_enable === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_queue: got write r%0d=%0h expected none", waddr, wdata);
        end else begin
          mon_w = wq.pop_front();
          chk("write_addr", waddr, mon_w.addr);
          chk("write_data", wdata, mon_w.data);
        end
      end
    end
  end

  initial begin
    bit acc;
    int k;
    int budget;
    logic [ADDR_W-1:0] r1, r2;

    repeat (2) @(negedge clk);
    check_reset_vals("init_reset");
    reset = 1'b0;
    in_reset = 1'b0;

    // ALU only
    cycle(1'b1, 4'd3, 24'hABCDEF, 1'b0, '0, '0, acc);
    idle(1);

    // Load bypass
    cycle(1'b0, '0, '0, 1'b1, 4'd5, 24'h123456, acc);
    chk("bypass_accept", acc, 1);
    idle(1);

    // Fill/drain: ALU busy on r0 for 6 cycles, loads r1..r6 held valid
    k = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'd0, 24'($urandom), 1'b1, ADDR_W'(k), 24'h100000 + 24'(k), acc);
      if (acc) k++;
    end
    chk("fill_count",   ld_count, 4);
    chk("fill_pending", pending, 16'h001E);
    chk("fill_ready",   ld_ready, 0);
    budget = 20;
    while (k <= 6 && budget > 0) begin
      cycle(1'b0, '0, '0, 1'b1, ADDR_W'(k), 24'h100000 + 24'(k), acc);
      if (acc) k++;
      budget--;
    end
    chk("fill_drain_budget", (k > 6), 1);
    idle(6);

    // Squash: buffered r7 load overtaken by a younger ALU write to r7
    cycle(1'b1, 4'd0, 24'h000001, 1'b1, 4'd7, 24'h000AAA, acc);
    chk("squash_pending_set", pending, 16'h0080);
    cycle(1'b1, 4'd7, 24'h000111, 1'b0, '0, '0, acc);
    chk("squash_pending_clr", pending, 0);
    idle(3);

    // Same-cycle conflict on r9
    cycle(1'b1, 4'd9, 24'h00BEEF, 1'b1, 4'd9, 24'h00DEAD, acc);
    chk("conflict_pending", pending, 0);
    chk("conflict_count",   ld_count, 1);
    idle(3);

    // Reset mid-operation with 3 buffered loads
    for (int i = 1; i <= 3; i++)
      cycle(1'b1, 4'd0, 24'h0, 1'b1, ADDR_W'(i), 24'h00C000 + 24'(i), acc);
    chk("prereset_count", ld_count, 3);
    do_reset();
    idle(5);

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      r1 = ($urandom % 2 == 0) ? ADDR_W'($urandom % 4) : ADDR_W'($urandom);
      r2 = ($urandom % 2 == 0) ? ADDR_W'($urandom % 4) : ADDR_W'($urandom);
      cycle(($urandom % 2) == 0, r1, 24'($urandom),
            ($urandom % 4) != 0, r2, 24'($urandom), acc);
      if ($urandom % 600 == 0) do_reset();
    end

    idle(10);
    chk("write_queue_drained",  wq.size(), 0);
    chk("status_queue_drained", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
